// File: rtl/guess_player.sv
// guess_player: automated player for the LED guessing game.
// Watches the game's y pattern, waits for REACT_TICKS consecutive one-hot
// y updates, presses the lit lane on b, and tallies wins/losses with
// saturating counters.
// Optional build macro: GUESS_PLAYER_MISS_EN -- on every fourth round
// (rnd==3) the press pattern is y rotated left, deliberately losing.
module guess_player #(
  parameter int REACT_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       start,
  input  logic [3:0] y,
  input  logic       win,
  input  logic       lose,
  output logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] wins,
  output logic [7:0] losses
);

  typedef enum logic [1:0] {IDLE, WATCH, PRESS, RELEASE} state_t;

  localparam logic [3:0] REACT = 4'(REACT_TICKS);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [3:0] b_nx;
  logic [7:0] wins_nx, losses_nx;
  logic [1:0] rnd, rnd_nx;
  logic       done_nx;
  logic       en_d;
  logic       y_onehot;
  logic [3:0] press_pat;

  assign y_onehot = $onehot(y);
  assign busy     = (state != IDLE);

`ifdef GUESS_PLAYER_MISS_EN
  // Fourth round of every group of four presses the wrong (rotated) lane
  assign press_pat = (rnd == 2'd3) ? {y[2:0], y[3]} : y;
`else
  assign press_pat = y;
`endif

  // Delay the game advance pulse: y is fresh on the edge after en
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) en_d <= 1'b0;
    else        en_d <= en;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Datapath registers: button vector, tick counter, tallies, round count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b      <= 4'd0;
      cnt    <= 4'd0;
      wins   <= 8'd0;
      losses <= 8'd0;
      rnd    <= 2'd0;
      done   <= 1'b0;
    end else begin
      b      <= b_nx;
      cnt    <= cnt_nx;
      wins   <= wins_nx;
      losses <= losses_nx;
      rnd    <= rnd_nx;
      done   <= done_nx;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    b_nx      = b;
    wins_nx   = wins;
    losses_nx = losses;
    rnd_nx    = rnd;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        b_nx = 4'd0;
        if (start) begin
          state_nx = WATCH;
          cnt_nx   = 4'd0;
        end
      end
      WATCH: begin
        // Press check runs every cycle so REACT_TICKS=0 needs no update
        if (y_onehot && cnt == REACT) begin
          b_nx     = press_pat;
          cnt_nx   = 4'd0;
          state_nx = PRESS;
        end else if (en_d) begin
          cnt_nx = y_onehot ? cnt + 4'd1 : 4'd0;
        end
      end
      PRESS: begin
        if (win) begin
          if (wins != 8'hFF) wins_nx = wins + 8'd1;
          b_nx     = 4'd0;
          state_nx = RELEASE;
        end else if (lose) begin
          if (losses != 8'hFF) losses_nx = losses + 8'd1;
          b_nx     = 4'd0;
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        if (!win && !lose) begin
          done_nx  = 1'b1;
          rnd_nx   = rnd + 2'd1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_guess_player.sv
// Bench for guess_player: directed rounds against a behavioural model of the
// player's round rules, compared every cycle, plus literal expectations.
module tb_guess_player;
  localparam int RT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, start = 1'b0, win = 1'b0, lose = 1'b0;
  logic [3:0] y = 4'd0;
  logic [3:0] b;
  logic       busy, done;
  logic [7:0] wins, losses;

  always #5 clk = ~clk;

  guess_player #(.REACT_TICKS(RT)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .y(y),
    .win(win), .lose(lose), .b(b), .busy(busy), .done(done),
    .wins(wins), .losses(losses)
  );

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: round phase, streak of one-hot updates, tallies
  int         m_phase = 0;   // 0 idle, 1 watching, 2 pressing, 3 releasing
  int         m_streak = 0;
  int         m_wins = 0, m_losses = 0, m_rnd = 0;
  bit         m_en_d = 0, m_done = 0, m_oh;
  logic [3:0] m_b = 4'd0, m_pat;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_streak = 0; m_wins = 0; m_losses = 0; m_rnd = 0;
      m_en_d = 0; m_done = 0; m_b = 4'd0;
    end else begin
      m_oh   = ($countones(y) == 1);
      m_done = 0;
`ifdef GUESS_PLAYER_MISS_EN
      m_pat = (m_rnd == 3) ? {y[2:0], y[3]} : y;
`else
      m_pat = y;
`endif
      if (m_phase == 0) begin
        if (start) begin m_phase = 1; m_streak = 0; end
      end else if (m_phase == 1) begin
        if (m_oh && m_streak == RT) begin
          m_b = m_pat; m_streak = 0; m_phase = 2;
        end else if (m_en_d) begin
          m_streak = m_oh ? m_streak + 1 : 0;
        end
      end else if (m_phase == 2) begin
        if (win) begin
          m_wins = (m_wins < 255) ? m_wins + 1 : 255; m_b = 0; m_phase = 3;
        end else if (lose) begin
          m_losses = (m_losses < 255) ? m_losses + 1 : 255; m_b = 0; m_phase = 3;
        end
      end else begin
        if (!win && !lose) begin
          m_done = 1; m_rnd = (m_rnd + 1) % 4; m_phase = 0;
        end
      end
      m_en_d = en;
    end
  end

  // Cycle-by-cycle compare, half a period after the active edge
  always @(negedge clk) begin
    check("b", b, m_b);
    check("busy", busy, m_phase != 0);
    check("done", done, m_done);
    check("wins", wins, m_wins);
    check("losses", losses, m_losses);
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // One round: y0 shown at start, then nupd y updates from y1..y3.
  // The game answers win if b matches y, else lose (when respond=1).
  task automatic play(input logic [3:0] y0, y1, y2, y3, input int nupd,
                      input bit respond, output logic [3:0] pressed, output int upd);
    logic [3:0] seq [4];
    seq[0] = y0; seq[1] = y1; seq[2] = y2; seq[3] = y3;
    upd = 0;
    y = seq[0]; start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= nupd; i++) begin
      if (b != 4'd0) break;
      en = 1'b1; tick(); en = 1'b0; y = seq[i]; tick();
      upd++;
    end
    for (int k = 0; k < 10 && b == 4'd0; k++) tick();
    check("press_seen", b != 4'd0, 1);
    pressed = b;
    if (respond) begin
      if (b == y) win = 1'b1; else lose = 1'b1;
      start = 1'b1;               // ignored while busy
      tick(); tick();
      win = 1'b0; lose = 1'b0; start = 1'b0;
      for (int k = 0; k < 10 && !done; k++) tick();
      check("done_seen", done, 1);
    end
  endtask

  logic [3:0] p;
  int         u;

  initial begin
    #1 reset = 1'b0;
    #1;
    check("rst_b", b, 4'd0);
    check("rst_busy", busy, 0);
    check("rst_wins", wins, 0);
    tick(); tick(); reset = 1'b1; tick();

    // Normal win: 0001 -> 0010 -> 0100
    play(4'b0001, 4'b0010, 4'b0100, 4'b0000, 2, 1, p, u);
    check("t1_press_b", p, 4'b0100);
    check("t1_updates", u, 2);
    check("t1_wins", wins, 1);
    check("t1_losses", losses, 0);
    check("t1_busy", busy, 0);

    // Invalid y mid-watch: 0110 clears the streak
    play(4'b0001, 4'b0110, 4'b0010, 4'b0100, 3, 1, p, u);
    check("t2_press_b", p, 4'b0100);
    check("t2_updates", u, 3);
    check("t2_wins", wins, 2);

    // Abort in PRESS with b=0010
    play(4'b0001, 4'b0100, 4'b0010, 4'b0000, 2, 0, p, u);
    check("t3_press_b", p, 4'b0010);
    reset = 1'b0;
    #1;
    check("t3_abort_b", b, 4'd0);
    check("t3_abort_busy", busy, 0);
    check("t3_abort_wins", wins, 0);
    check("t3_abort_losses", losses, 0);
    tick(); reset = 1'b1; tick(); tick();
    check("t3_idle_after", busy, 0);
    play(4'b1000, 4'b0001, 4'b0010, 4'b0000, 2, 1, p, u);
    check("t3_wins_after", wins, 1);

    // Four rounds from reset: miss build loses round 4
    reset = 1'b0; tick(); reset = 1'b1; tick();
    repeat (4) play(4'b0001, 4'b0010, 4'b1000, 4'b0000, 2, 1, p, u);
`ifdef GUESS_PLAYER_MISS_EN
    check("t4_press_rot", p, 4'b0001);
    check("t4_wins", wins, 3);
    check("t4_losses", losses, 1);
`else
    check("t4_press", p, 4'b1000);
    check("t4_wins", wins, 4);
    check("t4_losses", losses, 0);
`endif

    // Saturation: 257 won rounds (miss build loses every fourth)
    reset = 1'b0; tick(); reset = 1'b1; tick();
    repeat (257) play(4'b0001, 4'b0010, 4'b1000, 4'b0000, 2, 1, p, u);
`ifdef GUESS_PLAYER_MISS_EN
    check("t5_wins", wins, 193);
    check("t5_losses", losses, 64);
`else
    check("t5_wins", wins, 255);
    check("t5_losses", losses, 0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/guess_player.md
GUESS_PLAYER -- requirements
Module: guess_player

Interface
REQ-001 The block SHALL provide parameter REACT_TICKS, default 2, meaning the number of y updates observed before pressing (range 0..15).
REQ-002 The block SHALL provide port clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL provide port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 The block SHALL provide port en, input, 1 bit: the game advance pulse, shared with the guessing-game FSM (high at most 1 cycle, at least 2 cycles apart).
REQ-005 The block SHALL provide port start, input, 1 bit: arms one round; ignored while busy.
REQ-006 The block SHALL provide port y, input, 4 bits: the game LED pattern (one-hot lane, 4'b0110 lose, 4'b1111 win).
REQ-007 The block SHALL provide ports win and lose, input, 1 bit each: the game result flags.
REQ-008 The block SHALL provide port b, output, 4 bits, registered: the button vector driven into the game.
REQ-009 The block SHALL provide port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 The block SHALL provide port done, output, 1 bit: a 1-cycle pulse at round completion.
REQ-011 The block SHALL provide ports wins and losses, output, 8 bits each: saturating result counters.

Function
REQ-012 The FSM states SHALL be IDLE, WATCH, PRESS and RELEASE.
REQ-013 In IDLE, b SHALL be 0; when start=1, the FSM SHALL go to WATCH and clear the tick counter cnt (4 bits).
REQ-014 The block SHALL register en as en_d; a "y update" is a clk edge with en_d=1.
REQ-015 In WATCH, on each y update where y is one-hot, cnt SHALL increment; where y is not one-hot (0, 0110, 1111, other), cnt SHALL clear to 0.
REQ-016 In WATCH, on the first edge where cnt==REACT_TICKS and y is one-hot, b SHALL load the press pattern, cnt SHALL clear, and the FSM SHALL go to PRESS.
REQ-017 With REACT_TICKS=0, the press SHALL occur on the first WATCH cycle that sees a one-hot y, with no y update required.
REQ-018 By default the press pattern SHALL equal y.
REQ-019 In PRESS, b SHALL hold its value until win or lose is sampled high.
REQ-020 On the edge that PRESS samples win=1, wins SHALL increment, saturating at 255.
REQ-021 On the edge that PRESS samples lose=1 (and win=0), losses SHALL increment, saturating at 255.
REQ-022 If win and lose are both high in PRESS, only wins SHALL increment.
REQ-023 On leaving PRESS, b SHALL be cleared to 0 and the FSM SHALL go to RELEASE.
REQ-024 In RELEASE, the FSM SHALL wait until win=0 and lose=0, then pulse done for 1 cycle and return to IDLE.
REQ-025 start asserted in WATCH, PRESS or RELEASE SHALL have no effect.
REQ-026 A round counter rnd (2 bits, wrapping 3->0) SHALL increment on each done.

Reset
REQ-027 While reset=0, the FSM SHALL immediately, without waiting for clk, be IDLE with b=0, busy=0, done=0, cnt=0, rnd=0, wins=0, losses=0 and en_d=0.
REQ-028 Reset asserted mid-round (any state) SHALL abort the round with no counter update; b SHALL drop to 0 asynchronously.
REQ-029 After reset releases, the block SHALL be IDLE and SHALL require a fresh start.

Configuration
REQ-030 The macro GUESS_PLAYER_MISS_EN SHALL select deliberate-miss behaviour.
REQ-031 When GUESS_PLAYER_MISS_EN is defined and rnd==3, the press pattern SHALL be y rotated left ({y[2:0],y[3]}), forcing a loss; in all other rounds it SHALL equal y.
REQ-032 When GUESS_PLAYER_MISS_EN is undefined, the press pattern SHALL always equal y, and rnd SHALL still count but have no effect.

Verification
REQ-033 Reset: drive reset=0 at any time -> b=0000, busy=0, wins=0, losses=0 within the same cycle.
REQ-034 Normal win: REACT_TICKS=2, start, y sequence 0001->0010->0100 -> b=0100 after the second y update, game raises win, wins=1, b=0000, one done pulse.
REQ-035 Invalid y: y goes 0001, 0110, 0010 during WATCH -> cnt clears at 0110, and no press occurs until two one-hot updates have followed.
REQ-036 Saturation: 257 consecutive won rounds -> wins=255, losses=0.
REQ-037 Miss config: with GUESS_PLAYER_MISS_EN, 4 rounds -> round 4 presses the rotated lane, giving wins=3 and losses=1; without the macro -> wins=4 and losses=0.
REQ-038 Abort: reset=0 while in PRESS with b=0010 -> b=0000 immediately, busy=0, counters 0; start after release -> a normal round.
